disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Scan sequencer for the 4-digit multiplexed 7-segment display. It generates the 2-bit digit-select `scan` that drives the display mux, and holds the frame registers `hexs`/`point`/`les` that feed it. Host updates are double-buffered and committed only at frame boundaries, so a digit never changes value mid-frame. It also supplies a per-slot digit-enable for brightness PWM and leading-zero blanking.

## Interface
- `DIV_W`, 17: prescaler width; one digit slot lasts 2^DIV_W clocks (must be ≥ 3).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  single-cycle request to stage `hexs_in`/`point_in`/`les_in`.
- `hexs_in`  in  16  four hex nibbles; digit 0 = [3:0].
- `point_in`  in  4  decimal-point bits per digit.
- `les_in`  in  4  latch-enable bits per digit.
- `lz_en`  in  1  leading-zero suppression enable.
- `bright`  in  3  brightness, 0 = 1/8 duty, 7 = full duty.
- `scan`  out  2  current digit slot index, feeds the mux select.
- `hexs`  out  16  committed frame value, feeds the mux.
- `point`  out  4  committed decimal points.
- `les`  out  4  committed latch enables.
- `dig_on`  out  1  1 = current anode may be driven; 0 = force all anodes off.
- `ack`  out  1  one-cycle pulse on the cycle a staged load commits.
- `frame_done`  out  1  one-cycle pulse at the end of slot 3.

## Operation
- Prescaler `div[DIV_W-1:0]` increments every clock and wraps to 0. `tc = (div == all ones)`.
- On `tc`, `scan` increments modulo 4 (3 → 0).
- `frame_end = tc & (scan == 3)`. `frame_done` is registered and pulses on the cycle after `frame_end`.
- Staging: when `load` = 1, capture the three inputs into the staging registers and set `pending`.
- Commit: on `frame_end` with `pending` = 1, do the following.
  - Copy staging to `hexs`/`point`/`les`.
  - Clear `pending`.
  - Pulse `ack` on the next cycle, aligned with `frame_done`.
- `load` on the same cycle as a commit:
  - The previously staged value commits.
  - The new value is captured into staging.
  - `pending` stays 1, so the new value commits at the next frame end.
- Several loads between frame ends: only the last staged value commits.
- PWM: `pwm_ok = (div[DIV_W-1:DIV_W-3] <= bright)`.
- Leading-zero blank for slot i (i = 1..3): blank when `lz_en` = 1 and every nibble of `hexs` from digit 3 down to digit i is 0. Digit 0 is never blanked.
- `dig_on = pwm_ok & ~blank(scan)`. It is registered, and uses the same-cycle `div`/`scan`/`hexs` values.
- The block holds no other state. There is no FSM beyond the `scan` counter and the `pending` flag.

## Timing
- Reset (asynchronous, applied immediately):
  - `div`, `scan` = 0.
  - `hexs` = 16'h0000, `point` = 4'b0000, `les` = 4'b0000.
  - Staging registers = 0, `pending` = 0.
  - `dig_on` = 0, `ack` = 0, `frame_done` = 0.
- Reset release: first `dig_on` = 1 one clock after release (bright ≥ 0, slot 0 never blanked).
- Slot length is exactly 2^DIV_W clocks; frame length is 4·2^DIV_W clocks.
- `scan` changes on the clock edge following the `tc` cycle.
- Commit latency, from a `load` edge to `hexs` updated: at most 4·2^DIV_W + 1 clocks, at least 1 clock (when `load` falls on the cycle before `frame_end`).
- `dig_on` lags `div`/`scan` by one clock. The anode mux must therefore sample the registered `scan`. A one-clock overlap at a slot edge is acceptable, because `dig_on` is 0 at every slot start when `bright` < 7.
- Reset mid-frame: pending data is discarded, and the frame registers return to 0.

## Test plan
- DIV_W = 3, rst pulse → `scan` sequence 0,1,2,3,0 with 8 clocks per slot; `frame_done` pulses every 32 clocks.
- `load` with `hexs_in` = 16'h1234 at clock 5 of slot 1 → `hexs` stays 0 until after the slot-3 `tc`; then `hexs` = 16'h1234 with `ack` = 1 for exactly one cycle.
- Loads of 16'hAAAA then 16'h5555 in the same frame → only 16'h5555 commits; one `ack` only.
- `load` of 16'hBEEF coincident with a `frame_end` that commits 16'h1111 → 16'h1111 commits now; 16'hBEEF commits at the next frame; two `ack` pulses total.
- `lz_en` = 1, `hexs` = 16'h0050, bright = 7 → `dig_on` = 0 in slots 3 and 2, and 1 in slots 1 and 0. `hexs` = 16'h0000 → only slot 0 is on.
- bright = 0, DIV_W = 3 → `dig_on` = 1 for 1 of 8 clocks per slot. bright = 3 → 4 of 8. Assert `rst` mid-slot → all outputs 0 immediately.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display.
// A free-running prescaler divides each digit slot into 2^DIV_W clocks; the
// slot index `scan` walks 0..3. Host frame data is staged on `load` and only
// copied to the live frame registers at a frame boundary, so a digit never
// changes value mid-frame. `dig_on` gates the anodes for brightness PWM and
// leading-zero blanking.
module disp_scan_ctrl #(
    parameter int DIV_W = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] hexs_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  les_in,
    input  logic        lz_en,
    input  logic [2:0]  bright,
    output logic [1:0]  scan,
    output logic [15:0] hexs,
    output logic [3:0]  point,
    output logic [3:0]  les,
    output logic        dig_on,
    output logic        ack,
    output logic        frame_done
);

    typedef struct packed {
        logic [15:0] hexs;
        logic [3:0]  point;
        logic [3:0]  les;
    } frame_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div;
    logic             tc;
    logic             frame_end;
    logic             pending;
    logic             pwm_ok;
    logic [3:0]       blank;
    frame_t           stage;
    frame_t           cur;

    assign tc        = &div;
    assign frame_end = tc & (scan == 2'd3);
    assign pwm_ok    = (div[DIV_W-1 -: 3] <= bright);

    assign hexs  = cur.hexs;
    assign point = cur.point;
    assign les   = cur.les;

    // Per-slot leading-zero blank: slot i goes dark when every nibble from
    // digit 3 down to digit i is zero. Digit 0 always shows.
    assign blank[0] = 1'b0;
    for (genvar i = 1; i < 4; i++) begin : g_lz
        assign blank[i] = lz_en & ~|cur.hexs[15:4*i];
    end

    // Prescaler and digit-slot counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            scan <= 2'd0;
        end else begin
            div <= div + DIV_ONE;
            if (tc)
                scan <= scan + 2'd1;
        end
    end

    // Host staging buffer; a load coincident with a commit re-arms pending so
    // the new value goes out on the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage   <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                stage <= '{hexs: hexs_in, point: point_in, les: les_in};
            if (load)
                pending <= 1'b1;
            else if (frame_end)
                pending <= 1'b0;
        end
    end

    // Frame-boundary commit with ack / frame_done pulses on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= '0;
            ack        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            ack        <= frame_end & pending;
            if (frame_end & pending)
                cur <= stage;
        end
    end

    // Registered anode enable from this cycle's slot position and frame data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dig_on <= 1'b0;
        else
            dig_on <= pwm_ok & ~blank[scan];
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl with DIV_W = 3 (8 clocks per slot, 32 per frame).
// `k` counts clock edges since reset release; the prescaler state seen after
// edge k is div = k%8, scan = (k/8)%4. Committed frames are tracked in a
// scoreboard queue and checked when `ack` fires.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hexs_in = '0;
    logic [3:0]  point_in = '0;
    logic [3:0]  les_in = '0;
    logic        lz_en = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic [1:0]  scan;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    logic        dig_on;
    logic        ack;
    logic        frame_done;

    disp_scan_ctrl #(.DIV_W(3)) dut (
        .clk(clk), .rst(rst), .load(load), .hexs_in(hexs_in),
        .point_in(point_in), .les_in(les_in), .lz_en(lz_en), .bright(bright),
        .scan(scan), .hexs(hexs), .point(point), .les(les),
        .dig_on(dig_on), .ack(ack), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] h;
        logic [3:0]  p;
        logic [3:0]  l;
    } fr_t;

    typedef struct {
        logic [15:0] h;
        logic        lz;
        logic [2:0]  br;
        int          c0, c1, c2, c3;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   k = 0;
    bit   open_st = 1'b0;
    fr_t  q[$];
    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", nm, act, exp, k);
        end
    endtask

    // One clock; check slot counter, frame pulse, and any commit.
    task automatic tick();
        fr_t f;
        if (k % 32 == 31 && !load) open_st = 1'b0;
        @(posedge clk);
        k++;
        #1;
        chk("scan", scan, (k / 8) % 4);
        chk("frame_done", frame_done, (k % 32 == 0));
        if (ack) begin
            chk("ack_phase", k % 32, 0);
            if (q.size() == 0) begin
                chk("ack_unexpected", ack, 0);
            end else begin
                f = q.pop_front();
                chk("hexs_commit", hexs, f.h);
                chk("point_commit", point, f.p);
                chk("les_commit", les, f.l);
            end
        end
    endtask

    task automatic goto_phase(input int p);
        do tick(); while (k % 32 != p);
    endtask

    // Single-cycle load; a still-uncommitted staged value is superseded
    // unless this edge is itself a frame end.
    task automatic drive_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
        fr_t f;
        f = '{h: h, p: p, l: l};
        if (open_st && (k % 32 != 31)) void'(q.pop_back());
        q.push_back(f);
        open_st  = 1'b1;
        hexs_in  = h;
        point_in = p;
        les_in   = l;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic wait_commit();
        for (int i = 0; i < 200 && q.size() > 0; i++) tick();
        chk("commit_timeout_left", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt[4];
        int s;
        vt[0] = '{16'h0050, 1'b1, 3'd7, 8, 8, 0, 0};
        vt[1] = '{16'h0000, 1'b1, 3'd7, 8, 0, 0, 0};
        vt[2] = '{16'h0000, 1'b0, 3'd0, 1, 1, 1, 1};
        vt[3] = '{16'h1234, 1'b1, 3'd3, 4, 4, 4, 4};
        vt[4] = '{16'h0050, 1'b0, 3'd7, 8, 8, 8, 8};
        vt[5] = '{16'h0F00, 1'b1, 3'd5, 6, 6, 6, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_scan", scan, 0);
        chk("rst_hexs", hexs, 0);
        chk("rst_point", point, 0);
        chk("rst_les", les, 0);
        chk("rst_dig_on", dig_on, 0);
        chk("rst_ack", ack, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        k = 0;

        // Two frames of free-running scan at full brightness
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("dig_on_full", dig_on, 1);
        end

        // Load mid-slot-1 holds until the slot-3 tc, then one ack
        goto_phase(13);
        drive_load(16'h1234, 4'h5, 4'hA);
        goto_phase(31);
        chk("hexs_hold", hexs, 16'h0000);
        chk("ack_idle", ack, 0);
        tick();
        chk("ack_seen", ack, 1);
        tick();
        chk("ack_width", ack, 0);
        q.delete();

        // Two loads in one frame: only the last one commits
        goto_phase(3);
        drive_load(16'hAAAA, 4'h1, 4'h2);
        goto_phase(10);
        drive_load(16'h5555, 4'h3, 4'h4);
        wait_commit();
        chk("last_wins", hexs, 16'h5555);
        repeat (32) tick();

        // Load coincident with a committing frame end
        goto_phase(5);
        drive_load(16'h1111, 4'h6, 4'h7);
        goto_phase(31);
        drive_load(16'hBEEF, 4'h8, 4'h9);
        chk("coincident_first", hexs, 16'h1111);
        wait_commit();
        chk("coincident_second", hexs, 16'hBEEF);

        // PWM duty and leading-zero blanking per slot
        foreach (vt[n]) begin
            drive_load(vt[n].h, 4'h0, 4'h0);
            wait_commit();
            lz_en  = vt[n].lz;
            bright = vt[n].br;
            goto_phase(0);
            cnt = '{0, 0, 0, 0};
            for (int i = 0; i < 32; i++) begin
                tick();
                s = ((k - 1) % 32) / 8;
                if (dig_on) cnt[s]++;
            end
            chk($sformatf("duty_v%0d_s0", n), cnt[0], vt[n].c0);
            chk($sformatf("duty_v%0d_s1", n), cnt[1], vt[n].c1);
            chk($sformatf("duty_v%0d_s2", n), cnt[2], vt[n].c2);
            chk($sformatf("duty_v%0d_s3", n), cnt[3], vt[n].c3);
        end

        // Mid-slot reset discards pending data and clears everything at once
        lz_en  = 1'b0;
        bright = 3'd7;
        goto_phase(9);
        drive_load(16'hDEAD, 4'hF, 4'hF);
        goto_phase(13);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_scan", scan, 0);
        chk("mid_rst_hexs", hexs, 0);
        chk("mid_rst_point", point, 0);
        chk("mid_rst_les", les, 0);
        chk("mid_rst_dig_on", dig_on, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        q.delete();
        open_st = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        repeat (40) tick();
        chk("pending_discarded", hexs, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
